vga_sprite_engine: RTL and testbench
====================================

// Module: vga_sprite_engine
// PURPOSE
//  Parametrised VGA timing generator plus bouncing-sprite compositor, successor to the fixed
//  640x480 timing/box block. Generates h/v sync and data-enable for any mode, moves a
//  SPR_W x SPR_H sprite window that bounces off the active-area edges, and issues sequential
//  read addresses to an external sprite ROM (1-cycle latency). Outputs registered RGB332,
//  composited over a selectable background. Sits between the sprite ROM and the VGA DAC pins.
// PARAMETERS
//  H_SYNC   96   hsync pulse width, pixels        | V_SYNC   2    vsync pulse width, lines
//  H_BACK   48   h back porch, pixels             | V_BACK   33   v back porch, lines
//  H_ACTIVE 640  visible pixels per line          | V_ACTIVE 480  visible lines per frame
//  H_FRONT  16   h front porch, pixels            | V_FRONT  10   v front porch, lines
//  SPR_W    200  sprite width, pixels (<=H_ACTIVE) | SPR_H    200  sprite height, lines (<=V_ACTIVE)
//  STEP     1    sprite displacement per frame, pixels/lines (1..SPR_W-1)
//  ADDR_W   16   sprite ROM address width (2^ADDR_W >= SPR_W*SPR_H)
// PORTS
//  vga_clk      in   1       pixel clock
//  rst_n        in   1       asynchronous active-low reset
//  move_en      in   1       1: sprite moves each frame; 0: sprite frozen
//  mode         in   2       0 bars+sprite, 1 bars only, 2 sprite on black, 3 solid white
//  spr_dout     in   8       sprite ROM data, valid 1 cycle after spr_addr
//  spr_addr     out  ADDR_W  sprite ROM read address
//  h_sync       out  1       horizontal sync, active high during pulse
//  v_sync       out  1       vertical sync, active high during pulse
//  de           out  1       data enable, high in active area
//  frame_start  out  1       1-cycle pulse, aligned with first active pixel of a frame on de
//  r/g/b        out  3/3/2   pixel colour, RGB332
// BEHAVIOUR
//  - H_TOTAL=sum of H_*; V_TOTAL=sum of V_*. h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments on
//    h wrap, wraps 0 at V_TOTAL-1 & h wrap. Counters sized $clog2(TOTAL).
//  - Line order: sync, back, active, front. Active when h_cnt in [H_SYNC+H_BACK, +H_ACTIVE) and
//    v_cnt in [V_SYNC+V_BACK, +V_ACTIVE). ax/ay = active-relative coordinates.
//  - Stage 0 (counters) -> stage 1 (ROM access, sync/de delay) -> stage 2 (registered outputs).
//    h_sync, v_sync, de, frame_start, r/g/b all 2 cycles after the counters; mutually aligned.
//  - Sprite position X0 (0..H_ACTIVE-SPR_W), Y0 (0..V_ACTIVE-SPR_H), direction flags dx,dy
//    (1=increasing). Reset: X0=Y0=0, dx=dy=1.
//  - Position update only on last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) and
//    move_en=1. Per axis: if dir=1 and X0+STEP>=MAX -> X0=MAX, dir=0; if dir=0 and X0<=STEP
//    -> X0=0, dir=1; else X0+=/-=STEP. Edge hit clamps exactly; never exceeds range.
//  - in_spr = active & ax-X0<SPR_W & ay-Y0<SPR_H (unsigned, widened; no wrap alias).
//  - spr_addr: cleared to 0 on frame wrap; increments by 1 on every stage-0 in_spr cycle,
//    holds otherwise; after the last sprite pixel it equals SPR_W*SPR_H and holds until wrap.
//    Address presented is that of the current in_spr pixel (increment after use).
//  - Background (stage-1 ax/ay): ay<V_ACTIVE/3 red 111_000_00; <2*V_ACTIVE/3 green 000_111_00;
//    else blue 000_000_11.
//  - Stage 2 colour: de=0 -> 0. mode0: in_spr? spr_dout : bars. mode1: bars. mode2: in_spr?
//    spr_dout : 0. mode3: 8'hFF. mode sampled at stage 1; change takes effect next pixel.
//  - Reset values: h_cnt=v_cnt=0, spr_addr=0, h_sync=v_sync=de=frame_start=0, rgb=0.
//    Reset mid-frame restarts at h=v=0 immediately; first sync pulse 2 cycles after release.
//  - move_en toggling mid-frame has no effect until the frame-end update point.
// TESTING
//  1 Defaults, run 2 frames: h_sync period 800, high 96; v_sync period 420000 clk, high 1600;
//    de high 640 clk/line, 480 lines; frame_start once per frame on first de.
//  2 Defaults, mode1: lines 0-159 r=7 g=0 b=0, 160-319 g=7, 320-479 b=3; blanking rgb=0.
//  3 mode0, move_en=0, ROM model returns addr[7:0]: pixel (0,0)=0x00, (199,0)=0xC7,
//    (0,1)=200&0xFF=0xC8; pixel (200,0) shows red bar; spr_addr=40000 after sprite, 0 at wrap.
//  4 move_en=1, STEP=1: X0 reaches 440 after 440 frames then decrements; Y0 reaches 280 then
//    decrements; STEP=7: X0 clamps to 440 at frame 63, dx flips.
//  5 Small mode (H 4/2/16/2, V 1/1/8/1, SPR 4x4): exhaustive frame compare vs reference model
//    incl. 2-cycle alignment of sync/de/rgb.
//  6 Assert rst_n low mid-line for 3 clk: all outputs 0 async; counters/X0/Y0/dirs/addr reset;
//    timing restarts cleanly from h=v=0.

Source files
------------

// File: rtl/vga_sprite_engine_if.sv
// Pin bundle of the sprite engine: sprite ROM read port, run controls and VGA DAC outputs.
interface vga_sprite_engine_if #(
  parameter int ADDR_W = 16
);
  logic              move_en;
  logic [1:0]        mode;
  logic [7:0]        spr_dout;
  logic [ADDR_W-1:0] spr_addr;
  logic              h_sync;
  logic              v_sync;
  logic              de;
  logic              frame_start;
  logic [2:0]        r;
  logic [2:0]        g;
  logic [1:0]        b;

  modport master (
    input  move_en, mode, spr_dout,
    output spr_addr, h_sync, v_sync, de, frame_start, r, g, b
  );

  modport slave (
    output move_en, mode, spr_dout,
    input  spr_addr, h_sync, v_sync, de, frame_start, r, g, b
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// Parametrised VGA timing plus a bouncing sprite read from an external 1-cycle-latency ROM,
// composited over colour bars; all video outputs are registered two cycles after the counters.
module vga_sprite_engine #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int SPR_W    = 200,
  parameter int SPR_H    = 200,
  parameter int STEP     = 1,
  parameter int ADDR_W   = 16
) (
  input  logic                vga_clk,
  input  logic                rst_n,
  vga_sprite_engine_if.master bus
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // One spare bit on every coordinate so range ends and sums never wrap.
  localparam logic [HW:0] HS_END = (HW+1)'(H_SYNC);
  localparam logic [HW:0] H_OFF  = (HW+1)'(H_SYNC + H_BACK);
  localparam logic [HW:0] H_END  = (HW+1)'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HW:0] H_LAST = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] X_MAX  = (HW+1)'(H_ACTIVE - SPR_W);
  localparam logic [HW:0] X_STEP = (HW+1)'(STEP);
  localparam logic [HW:0] SPR_WC = (HW+1)'(SPR_W);
  localparam logic [VW:0] VS_END = (VW+1)'(V_SYNC);
  localparam logic [VW:0] V_OFF  = (VW+1)'(V_SYNC + V_BACK);
  localparam logic [VW:0] V_END  = (VW+1)'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [VW:0] V_LAST = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] Y_MAX  = (VW+1)'(V_ACTIVE - SPR_H);
  localparam logic [VW:0] Y_STEP = (VW+1)'(STEP);
  localparam logic [VW:0] SPR_HC = (VW+1)'(SPR_H);
  localparam logic [VW:0] BAR1   = (VW+1)'(V_ACTIVE / 3);
  localparam logic [VW:0] BAR2   = (VW+1)'(2 * V_ACTIVE / 3);

  function automatic logic [7:0] bar_colour(input logic [VW:0] ay);
    logic [7:0] c;
    if (ay < BAR1)      c = 8'hE0;
    else if (ay < BAR2) c = 8'h1C;
    else                c = 8'h03;
    return c;
  endfunction

  logic [HW-1:0]     h_cnt_p0;
  logic [VW-1:0]     v_cnt_p0;
  logic [ADDR_W-1:0] spr_addr_p0;
  logic [HW:0]       x0, x0_nxt, hx, ax_p0;
  logic [VW:0]       y0, y0_nxt, vy, ay_p0;
  logic              dx, dx_nxt, dy, dy_nxt;
  logic              h_last, frame_last, vld_p0, in_spr_p0, fs_p0;

  assign hx         = {1'b0, h_cnt_p0};
  assign vy         = {1'b0, v_cnt_p0};
  assign ax_p0      = hx - H_OFF;
  assign ay_p0      = vy - V_OFF;
  assign h_last     = (hx == H_LAST);
  assign frame_last = h_last && (vy == V_LAST);
  assign vld_p0     = (hx >= H_OFF) && (hx < H_END) && (vy >= V_OFF) && (vy < V_END);
  assign in_spr_p0  = vld_p0 && ((ax_p0 - x0) < SPR_WC) && ((ay_p0 - y0) < SPR_HC);
  assign fs_p0      = vld_p0 && (ax_p0 == '0) && (ay_p0 == '0);

  // Bounce: an edge hit clamps exactly onto the limit and flips direction.
  always_comb begin
    x0_nxt = x0;
    dx_nxt = dx;
    y0_nxt = y0;
    dy_nxt = dy;
    if (frame_last && bus.move_en) begin
      if (dx) begin
        if (x0 + X_STEP >= X_MAX) begin x0_nxt = X_MAX; dx_nxt = 1'b0; end
        else                            x0_nxt = x0 + X_STEP;
      end else begin
        if (x0 <= X_STEP) begin x0_nxt = '0; dx_nxt = 1'b1; end
        else                    x0_nxt = x0 - X_STEP;
      end
      if (dy) begin
        if (y0 + Y_STEP >= Y_MAX) begin y0_nxt = Y_MAX; dy_nxt = 1'b0; end
        else                            y0_nxt = y0 + Y_STEP;
      end else begin
        if (y0 <= Y_STEP) begin y0_nxt = '0; dy_nxt = 1'b1; end
        else                    y0_nxt = y0 - Y_STEP;
      end
    end
  end

  // Stage 0: raster counters, sprite position and ROM address.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0    <= '0;
      v_cnt_p0    <= '0;
      spr_addr_p0 <= '0;
      x0          <= '0;
      y0          <= '0;
      dx          <= 1'b1;
      dy          <= 1'b1;
    end else begin
      h_cnt_p0 <= h_last ? '0 : h_cnt_p0 + HW'(1);
      if (h_last) v_cnt_p0 <= (vy == V_LAST) ? '0 : v_cnt_p0 + VW'(1);
      if (frame_last)     spr_addr_p0 <= '0;
      else if (in_spr_p0) spr_addr_p0 <= spr_addr_p0 + ADDR_W'(1);
      x0 <= x0_nxt;
      y0 <= y0_nxt;
      dx <= dx_nxt;
      dy <= dy_nxt;
    end
  end

  // Stage 1: timing delayed to line up with the ROM data.
  logic          hs_p1, vs_p1, vld_p1, fs_p1, spr_p1;
  logic [VW:0]   ay_p1;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      fs_p1  <= 1'b0;
      spr_p1 <= 1'b0;
    end else begin
      hs_p1  <= hx < HS_END;
      vs_p1  <= vy < VS_END;
      vld_p1 <= vld_p0;
      fs_p1  <= fs_p0;
      spr_p1 <= in_spr_p0;
    end
  end

  always_ff @(posedge vga_clk) ay_p1 <= ay_p0;

  logic [7:0] rgb_d;

  always_comb begin
    rgb_d = 8'h00;
    if (vld_p1) begin
      case (bus.mode)
        2'd0:    rgb_d = spr_p1 ? bus.spr_dout : bar_colour(ay_p1);
        2'd1:    rgb_d = bar_colour(ay_p1);
        2'd2:    rgb_d = spr_p1 ? bus.spr_dout : 8'h00;
        default: rgb_d = 8'hFF;
      endcase
    end
  end

  // Stage 2: registered DAC outputs.
  logic       hs_p2, vs_p2, vld_p2, fs_p2;
  logic [7:0] rgb_p2;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      vld_p2 <= 1'b0;
      fs_p2  <= 1'b0;
      rgb_p2 <= 8'h00;
    end else begin
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      vld_p2 <= vld_p1;
      fs_p2  <= fs_p1;
      rgb_p2 <= rgb_d;
    end
  end

  assign bus.spr_addr    = spr_addr_p0;
  assign bus.h_sync      = hs_p2;
  assign bus.v_sync      = vs_p2;
  assign bus.de          = vld_p2;
  assign bus.frame_start = fs_p2;
  assign bus.r           = rgb_p2[7:5];
  assign bus.g           = rgb_p2[4:2];
  assign bus.b           = rgb_p2[1:0];
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine in a small video mode: per-cycle reference model of the raster,
// plus hand-computed pixel tables, bounce positions, address wrap and mid-line reset.
module tb_vga_sprite_engine;
  localparam int HS = 4, HB = 2, HA = 16, HF = 2;
  localparam int VS = 1, VB = 1, VA = 8, VF = 1;
  localparam int SW = 4, SH = 4, STP = 3, AW = 8;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int HOFF = HS + HB, VOFF = VS + VB;
  localparam int XMAX = HA - SW, YMAX = VA - SH;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;

  vga_sprite_engine_if #(.ADDR_W(AW)) ifc ();

  vga_sprite_engine #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SPR_W(SW), .SPR_H(SH), .STEP(STP), .ADDR_W(AW)
  ) dut (
    .vga_clk(vga_clk),
    .rst_n  (rst_n),
    .bus    (ifc)
  );

  always #5 vga_clk = ~vga_clk;

  // Sprite ROM: one cycle of latency, contents equal the low address byte.
  always @(posedge vga_clk) ifc.spr_dout <= ifc.spr_addr;

  typedef struct {
    logic [1:0] mode;
    int         ax;
    int         ay;
    int         exp;
  } vec_t;

  vec_t tbl [14];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   n;            // counted clock edges since reset release
  int   mx, my, mdx, mdy, pmx, pmy;

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      if (err_cnt <= 40) $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; mx = 0; my = 0; mdx = 1; mdy = 1; pmx = 0; pmy = 0;
  endtask

  task automatic advance(inout int pos, inout int dir, input int lim);
    if (dir == 1) begin
      if (pos + STP >= lim) begin pos = lim; dir = 0; end
      else pos = pos + STP;
    end else begin
      if (pos <= STP) begin pos = 0; dir = 1; end
      else pos = pos - STP;
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic check_outputs(input logic [1:0] m);
    int p, h, v, ax, ay, px, py, sh, sv, rows, cols;
    int e_hs, e_vs, e_de, e_fs, e_rgb, bars;
    bit ins;
    e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_rgb = 0;
    if (n >= 2) begin
      p  = n - 2;
      h  = p % HT;
      v  = (p / HT) % VT;
      ax = h - HOFF;
      ay = v - VOFF;
      px = (n % FT < 2) ? pmx : mx;
      py = (n % FT < 2) ? pmy : my;
      e_hs = (h < HS) ? 1 : 0;
      e_vs = (v < VS) ? 1 : 0;
      e_de = (ax >= 0 && ax < HA && ay >= 0 && ay < VA) ? 1 : 0;
      e_fs = (e_de == 1 && ax == 0 && ay == 0) ? 1 : 0;
      ins  = e_de == 1 && ax >= px && ax < px + SW && ay >= py && ay < py + SH;
      bars = (ay < VA / 3) ? 'hE0 : (ay < 2 * VA / 3) ? 'h1C : 'h03;
      if (e_de == 1) begin
        case (m)
          2'd0:    e_rgb = ins ? (((ay - py) * SW + (ax - px)) & 255) : bars;
          2'd1:    e_rgb = bars;
          2'd2:    e_rgb = ins ? (((ay - py) * SW + (ax - px)) & 255) : 0;
          default: e_rgb = 'hFF;
        endcase
      end
    end
    sh   = n % HT;
    sv   = (n / HT) % VT;
    rows = clamp(sv - VOFF - my, 0, SH);
    cols = (sv - VOFF - my >= 0 && sv - VOFF - my < SH) ? clamp(sh - HOFF - mx, 0, SW) : 0;
    chk("h_sync", int'(ifc.h_sync), e_hs);
    chk("v_sync", int'(ifc.v_sync), e_vs);
    chk("de", int'(ifc.de), e_de);
    chk("frame_start", int'(ifc.frame_start), e_fs);
    chk("rgb", int'({ifc.r, ifc.g, ifc.b}), e_rgb);
    chk("spr_addr", int'(ifc.spr_addr), rows * SW + cols);
  endtask

  // One clock: record what the DUT sees at the edge, then check #1 after it.
  task automatic step();
    logic [1:0] m;
    logic       me;
    m  = ifc.mode;
    me = ifc.move_en;
    @(posedge vga_clk);
    #1;
    if (rst_n) begin
      if (n % FT == FT - 1) begin
        pmx = mx;
        pmy = my;
        if (me) begin
          advance(mx, mdx, XMAX);
          advance(my, mdy, YMAX);
        end
      end
      n++;
    end
    check_outputs(m);
  endtask

  task automatic wait_pix(input int f, input int ax, input int ay);
    int p;
    for (int i = 0; i < 8 * FT; i++) begin
      step();
      if (n >= 2) begin
        p = n - 2;
        if (p % HT == HOFF + ax && (p / HT) % VT == VOFF + ay && (f < 0 || p / FT == f)) return;
      end
    end
    vec_cnt++;
    err_cnt++;
    $display("FAIL wait_pix frame %0d pixel (%0d,%0d): not reached, required within %0d cycles", f, ax, ay, 8 * FT);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'd0, 0,  0, 'h00};
    tbl[1]  = '{2'd0, 3,  0, 'h03};
    tbl[2]  = '{2'd0, 0,  1, 'h04};
    tbl[3]  = '{2'd0, 3,  3, 'h0F};
    tbl[4]  = '{2'd0, 4,  0, 'hE0};
    tbl[5]  = '{2'd0, 5,  3, 'h1C};
    tbl[6]  = '{2'd0, 0,  6, 'h03};
    tbl[7]  = '{2'd1, 0,  0, 'hE0};
    tbl[8]  = '{2'd1, 10, 4, 'h1C};
    tbl[9]  = '{2'd1, 15, 7, 'h03};
    tbl[10] = '{2'd2, 2,  1, 'h06};
    tbl[11] = '{2'd2, 8,  1, 'h00};
    tbl[12] = '{2'd3, 0,  0, 'hFF};
    tbl[13] = '{2'd3, 15, 7, 'hFF};

    ifc.mode    = 2'd0;
    ifc.move_en = 1'b0;
    model_reset();
    repeat (3) step();
    @(negedge vga_clk) rst_n = 1'b1;

    // Frozen sprite at the origin: hand-computed pixels for every mode.
    for (int i = 0; i < 14; i++) begin
      ifc.mode = tbl[i].mode;
      wait_pix(-1, tbl[i].ax, tbl[i].ay);
      chk($sformatf("tbl[%0d]", i), int'({ifc.r, ifc.g, ifc.b}), tbl[i].exp);
    end

    // Address sits at SPR_W*SPR_H through the frame tail and clears at wrap.
    while (n % FT != FT - 1) step();
    chk("addr_end", int'(ifc.spr_addr), SW * SH);
    step();
    chk("addr_wrap", int'(ifc.spr_addr), 0);

    // Mid-line asynchronous reset while a visible pixel is on the outputs.
    ifc.mode = 2'd0;
    wait_pix(-1, 5, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_de", int'(ifc.de), 0);
    chk("rst_rgb", int'({ifc.r, ifc.g, ifc.b}), 0);
    chk("rst_h_sync", int'(ifc.h_sync), 0);
    chk("rst_addr", int'(ifc.spr_addr), 0);
    model_reset();
    ifc.move_en = 1'b1;
    repeat (3) step();
    @(negedge vga_clk) rst_n = 1'b1;
    step();
    step();
    chk("first_hsync", int'(ifc.h_sync), 1);

    // Bounce with STEP=3: X 0,3,6,9,12(clamp),9  Y 0,3,4(clamp),1,0,3.
    wait_pix(2, 9, 3);  chk("f2_above_spr", int'({ifc.r, ifc.g, ifc.b}), 'h1C);
    wait_pix(2, 9, 7);  chk("f2_spr_last", int'({ifc.r, ifc.g, ifc.b}), 'h0F);
    wait_pix(4, 11, 3); chk("f4_left_of_spr", int'({ifc.r, ifc.g, ifc.b}), 'h1C);
    wait_pix(4, 15, 3); chk("f4_spr_clamped", int'({ifc.r, ifc.g, ifc.b}), 'h0F);
    wait_pix(5, 9, 3);  chk("f5_spr_first", int'({ifc.r, ifc.g, ifc.b}), 'h00);
    wait_pix(5, 12, 6); chk("f5_spr_last", int'({ifc.r, ifc.g, ifc.b}), 'h0F);

    // Randomised mode and move_en changes against the model.
    for (int i = 0; i < 50 * FT; i++) begin
      step();
      if ($urandom_range(0, 31) == 0) ifc.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) ifc.move_en = ~ifc.move_en;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
